mod_inv_fermat: RTL and testbench

//  Modular inverse inv = a^(P-2) mod P (Fermat), computed by left-to-right square-and-multiply.

---
 rtl/ecc_pkg.sv | 34 +++
 rtl/mod_inv_fermat.sv | 131 +++++++++++++
 tb/tb_mod_inv_fermat.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared field constants, exponent helpers and controller state encoding
// for the Fermat-inversion block that sits on the modular multiplier.
package ecc_pkg;

    // Default field: operand width and prime (overridable per instance)
    localparam int           W = 256;
    localparam logic [W-1:0] P = 256'h7;
    localparam logic [W-1:0] E = P - 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SQR_REQ  = 3'd1,
        SQR_WAIT = 3'd2,
        MUL_REQ  = 3'd3,
        MUL_WAIT = 3'd4,
        FIN      = 3'd5
    } state_t;

    // Index of the most significant set bit; 0 when e is 0 or 1
    function automatic int msb_index(input logic [W-1:0] e);
        int idx;
        idx = 0;
        for (int k = 0; k < W; k++) begin
            if (e[k]) idx = k;
        end
        return idx;
    endfunction

    // Exponent bit select; with a constant exponent this folds to a small mux
    function automatic logic exp_bit(input logic [W-1:0] e, input int idx);
        return e[idx];
    endfunction

endpackage

// File: rtl/mod_inv_fermat.sv
// Modular inverse a^(P-2) mod P by left-to-right square-and-multiply.
// Every square/multiply is issued to an external modular multiplier over a
// start/done handshake; the running power r is the only product held here.
module mod_inv_fermat #(
    parameter int           W = ecc_pkg::W,
    parameter logic [W-1:0] P = ecc_pkg::P
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] inv_out,
    output logic         mul_start,
    output logic [W-1:0] mul_x,
    output logic [W-1:0] mul_y,
    input  logic [W-1:0] mul_res,
    input  logic         mul_done
);
    import ecc_pkg::*;

    // Exponent and the position of its leading one, both elaboration-time
    localparam logic [W-1:0] EXP = P - 2;
    localparam int           TOP = msb_index(EXP);
    localparam int           IW  = $clog2(W);

    state_t         state;
    state_t         state_nx;
    logic [W-1:0]   a;
    logic [W-1:0]   r;
    logic [IW-1:0]  i;
    logic           bit_set;
    logic           last_bit;

    assign bit_set  = exp_bit(EXP, int'(i));
    assign last_bit = (i == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: one square per remaining exponent bit, plus a multiply
    // after each square whose bit is set
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (a_in == '0)    state_nx = FIN;
                    else if (TOP == 0) state_nx = FIN;
                    else               state_nx = SQR_REQ;
                end
            end
            SQR_REQ:  state_nx = SQR_WAIT;
            SQR_WAIT: begin
                if (mul_done) begin
                    if (bit_set)       state_nx = MUL_REQ;
                    else if (last_bit) state_nx = FIN;
                    else               state_nx = SQR_REQ;
                end
            end
            MUL_REQ:  state_nx = MUL_WAIT;
            MUL_WAIT: begin
                if (mul_done) begin
                    if (last_bit) state_nx = FIN;
                    else          state_nx = SQR_REQ;
                end
            end
            FIN:      state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Datapath: operand latch, running power, bit index and result.
    // The result is written on the transition into FIN so it is already
    // valid while done is high, and is otherwise left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            a       <= '0;
            r       <= '0;
            i       <= '0;
            err     <= 1'b0;
            inv_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a   <= a_in;
                        r   <= a_in;
                        i   <= IW'(TOP - 1);
                        err <= (a_in == '0);
                        if (a_in == '0)    inv_out <= '0;
                        else if (TOP == 0) inv_out <= a_in;
                    end
                end
                SQR_WAIT: begin
                    if (mul_done) begin
                        r <= mul_res;
                        if (!bit_set) begin
                            if (last_bit) inv_out <= mul_res;
                            else          i <= i - 1'b1;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (mul_done) begin
                        r <= mul_res;
                        if (last_bit) inv_out <= mul_res;
                        else          i <= i - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; operands come straight from r and a,
    // which only change on mul_done, so they stay stable through each request
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FIN);
        mul_start = (state == SQR_REQ) || (state == MUL_REQ);
        mul_x     = r;
        mul_y     = ((state == MUL_REQ) || (state == MUL_WAIT)) ? a : r;
    end

endmodule

// File: tb/tb_mod_inv_fermat.sv
// Bench for mod_inv_fermat: directed vectors against a behavioural modular
// multiplier with adjustable latency, on a P=7 and a P=3 instance.

// Behavioural multiplier: done pulses lat cycles after the start cycle.
// Counts requests, completions and protocol violations (re-request while
// pending, operands moving while pending).
module tb_modmul_model #(
    parameter int           W = 256,
    parameter logic [W-1:0] P = 256'd7
) (
    input  logic         clk,
    input  logic         rst,
    input  int           lat,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         spur,
    output logic         done,
    output logic [W-1:0] res,
    output int           n_start,
    output int           n_done,
    output int           viol
);
    logic           pend;
    logic           done_r;
    int             cnt;
    logic [W-1:0]   xc;
    logic [W-1:0]   yc;
    logic [2*W-1:0] prod;

    assign prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    assign done = done_r | spur;

    always @(posedge clk) begin
        done_r <= 1'b0;
        if (rst) begin
            pend    <= 1'b0;
            cnt     <= 0;
            xc      <= '0;
            yc      <= '0;
            res     <= '0;
            n_start <= 0;
            n_done  <= 0;
            viol    <= 0;
        end else begin
            if (pend && (start || x != xc || y != yc)) viol <= viol + 1;
            if (pend) begin
                if (cnt <= 1) begin
                    done_r <= 1'b1;
                    pend   <= 1'b0;
                    n_done <= n_done + 1;
                end else begin
                    cnt <= cnt - 1;
                end
            end else if (start) begin
                n_start <= n_start + 1;
                xc      <= x;
                yc      <= y;
                res     <= W'(prod % {{W{1'b0}}, P});
                if (lat <= 1) begin
                    done_r <= 1'b1;
                    n_done <= n_done + 1;
                end else begin
                    pend <= 1'b1;
                    cnt  <= lat - 1;
                end
            end
        end
    end
endmodule

module tb_mod_inv_fermat;
    localparam int W = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         start7 = 1'b0;
    logic [W-1:0] a7 = '0;
    logic         busy7, done7, err7, ms7, md7;
    logic [W-1:0] inv7, mx7, my7, mr7;
    int           lat7 = 3;
    logic         spur7 = 1'b0;
    int           ns7, nd7, vi7;

    logic         start3 = 1'b0;
    logic [W-1:0] a3 = '0;
    logic         busy3, done3, err3, ms3, md3;
    logic [W-1:0] inv3, mx3, my3, mr3;
    int           lat3 = 2;
    logic         spur3 = 1'b0;
    int           ns3, nd3, vi3;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mod_inv_fermat #(.W(W), .P(256'd7)) dut7 (
        .clk(clk), .rst(rst), .start(start7), .a_in(a7),
        .busy(busy7), .done(done7), .err(err7), .inv_out(inv7),
        .mul_start(ms7), .mul_x(mx7), .mul_y(my7),
        .mul_res(mr7), .mul_done(md7)
    );

    tb_modmul_model #(.W(W), .P(256'd7)) mm7 (
        .clk(clk), .rst(rst), .lat(lat7), .start(ms7), .x(mx7), .y(my7),
        .spur(spur7), .done(md7), .res(mr7),
        .n_start(ns7), .n_done(nd7), .viol(vi7)
    );

    mod_inv_fermat #(.W(W), .P(256'd3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a_in(a3),
        .busy(busy3), .done(done3), .err(err3), .inv_out(inv3),
        .mul_start(ms3), .mul_x(mx3), .mul_y(my3),
        .mul_res(mr3), .mul_done(md3)
    );

    tb_modmul_model #(.W(W), .P(256'd3)) mm3 (
        .clk(clk), .rst(rst), .lat(lat3), .start(ms3), .x(mx3), .y(my3),
        .spur(spur3), .done(md3), .res(mr3),
        .n_start(ns3), .n_done(nd3), .viol(vi3)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Cycle index counts from the start cycle (0); entry is one cycle past an edge
    task automatic wait_done7(input int c0, output int cyc);
        cyc = c0;
        while (done7 !== 1'b1 && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (done7 !== 1'b1) chk("done7_timeout", 256'(0), 256'(1));
    endtask

    task automatic run7(input logic [W-1:0] av, output int lat, output logic [W-1:0] inv,
                        output logic e);
        @(negedge clk);
        a7 = av; start7 = 1'b1;
        @(posedge clk); #1;
        start7 = 1'b0;
        wait_done7(1, lat);
        inv = inv7;
        e   = err7;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, s0, d0, v0, c, av, lcur;
        logic [W-1:0] inv, hold;
        logic         e, seen;
        int           inv_tab [7];
        inv_tab = '{0, 1, 4, 5, 2, 3, 6};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  256'(busy7), 256'(0));
        chk("rst_done",  256'(done7), 256'(0));
        chk("rst_err",   256'(err7),  256'(0));
        chk("rst_mstart",256'(ms7),   256'(0));
        chk("rst_inv",   inv7,        256'(0));
        chk("rst_mulx",  mx7,         256'(0));
        chk("rst_muly",  my7,         256'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: a=3, L=3: square 2, square 4, multiply 5; 3 multiplies
        lat7 = 3;
        s0 = ns7;
        run7(256'd3, lat, inv, e);
        chk("t1_inv",  inv,          256'(5));
        chk("t1_err",  256'(e),      256'(0));
        chk("t1_lat",  256'(lat),    256'(13));
        chk("t1_muls", 256'(ns7 - s0), 256'(3));
        @(posedge clk); #1;
        chk("t1_busy_after", 256'(busy7), 256'(0));
        chk("t1_inv_hold",   inv7,        256'(5));

        // 2: a=1 then a=6 with start held high across the done cycle
        @(negedge clk);
        a7 = 256'd1; start7 = 1'b1;
        @(posedge clk); #1;
        wait_done7(1, lat);
        chk("t2_inv1", inv7, 256'(1));
        a7 = 256'd6;
        @(posedge clk); #1;
        chk("t2_gap_idle", 256'(busy7), 256'(0));
        @(posedge clk); #1;
        chk("t2_reaccept", 256'(busy7), 256'(1));
        start7 = 1'b0;
        wait_done7(1, lat);
        chk("t2_inv6", inv7, 256'(6));
        chk("t2_lat6", 256'(lat), 256'(13));
        @(posedge clk); #1;

        // 3: a=0 -> error, no multiplier traffic, straight to FIN
        s0 = ns7;
        run7(256'd0, lat, inv, e);
        chk("t3_err",  256'(e),        256'(1));
        chk("t3_inv",  inv,            256'(0));
        chk("t3_lat",  256'(lat),      256'(1));
        chk("t3_muls", 256'(ns7 - s0), 256'(0));
        @(posedge clk); #1;

        // 4: P=3 -> exponent 1, no multiplies; inverse of 2 is 2
        @(negedge clk);
        a3 = 256'd2; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        c = 1;
        while (done3 !== 1'b1 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("t4_inv",  inv3,        256'(2));
        chk("t4_err",  256'(err3),  256'(0));
        chk("t4_lat",  256'(c),     256'(1));
        chk("t4_muls", 256'(ns3),   256'(0));

        // 5: reset during the final multiply wait abandons the run
        @(negedge clk);
        a7 = 256'd3; start7 = 1'b1;
        @(posedge clk); #1;
        start7 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("t5_in_mulwait", 256'(busy7), 256'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_busy", 256'(busy7), 256'(0));
        chk("t5_done", 256'(done7), 256'(0));
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done7 === 1'b1) seen = 1'b1;
        end
        chk("t5_no_done", 256'(seen), 256'(0));
        run7(256'd5, lat, inv, e);
        chk("t5_inv", inv, 256'(3));
        @(posedge clk); #1;

        // 6: random operands, L alternating 1/7, spurious done while idle,
        //    start pulses while busy
        v0 = vi7; s0 = ns7; d0 = nd7;
        for (int k = 0; k < 10; k++) begin
            lcur = (k % 2 == 1) ? 7 : 1;
            lat7 = lcur;
            av   = int'($urandom_range(1, 6));
            hold = inv7;
            @(negedge clk); spur7 = 1'b1;
            @(negedge clk); spur7 = 1'b0;
            @(posedge clk); #1;
            chk("t6_spur_idle", 256'(busy7), 256'(0));
            chk("t6_spur_hold", inv7, hold);
            @(negedge clk);
            a7 = W'(av); start7 = 1'b1;
            @(posedge clk); #1;
            start7 = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            start7 = 1'b1; a7 = W'((av % 6) + 1);
            @(posedge clk); #1;
            start7 = 1'b0; a7 = W'(av);
            wait_done7(4, lat);
            chk("t6_inv_tab",  inv7, W'(inv_tab[av]));
            chk("t6_prod_one", 256'((av * int'(inv7[31:0])) % 7), 256'(1));
            chk("t6_lat",      256'(lat), 256'(1 + 3 * (lcur + 1)));
            chk("t6_err",      256'(err7), 256'(0));
            @(posedge clk); #1;
        end
        chk("t6_protocol", 256'(vi7 - v0), 256'(0));
        chk("t6_pairs",    256'(ns7 - s0), 256'(nd7 - d0));
        chk("t6_nmul",     256'(ns7 - s0), 256'(30));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
